// File: rtl/car_pkg.sv
// Shared types and constants for the car sensor driver.
//   car_drv_state_t : sequencer states IDLE -> PH1 -> PH2 -> PH3 -> GAP
//   car_dir_t       : direction of the car being emulated
//   BEAM_*          : {outer, inner} beam encodings
//   beam_pattern()  : {outer, inner} for a given state and direction
package car_pkg;

  typedef enum logic [2:0] {S_IDLE, S_PH1, S_PH2, S_PH3, S_GAP} car_drv_state_t;
  typedef enum logic {DIR_ENTER, DIR_EXIT} car_dir_t;

  localparam logic [1:0] BEAM_NONE  = 2'b00;
  localparam logic [1:0] BEAM_OUTER = 2'b10;
  localparam logic [1:0] BEAM_INNER = 2'b01;
  localparam logic [1:0] BEAM_BOTH  = 2'b11;

  // An entering car breaks the outer beam first; an exiting car the inner one.
  function automatic logic [1:0] beam_pattern(car_drv_state_t st, car_dir_t dir);
    logic [1:0] beams;
    beams = BEAM_NONE;
    case (st)
      S_PH1:   beams = (dir == DIR_ENTER) ? BEAM_OUTER : BEAM_INNER;
      S_PH2:   beams = BEAM_BOTH;
      S_PH3:   beams = (dir == DIR_ENTER) ? BEAM_INNER : BEAM_OUTER;
      default: beams = BEAM_NONE;
    endcase
    return beams;
  endfunction

endpackage

// File: rtl/car_sensor_driver_if.sv
// Request/beam bus between a requester (master) and car_sensor_driver (slave).
//   dwell, enter_req, exit_req : requester -> driver
//   ready, outer, inner, done  : driver -> requester
//   occupancy                  : driver -> requester, only with CAR_OCCUPANCY_EN defined
interface car_sensor_driver_if #(
  parameter int unsigned DWELL_W = 8
`ifdef CAR_OCCUPANCY_EN
  ,
  parameter int unsigned OCC_W   = 5
`endif
);

  logic [DWELL_W-1:0] dwell;
  logic               enter_req;
  logic               exit_req;
  logic               ready;
  logic               outer;
  logic               inner;
  logic               done;
`ifdef CAR_OCCUPANCY_EN
  logic [OCC_W-1:0]   occupancy;

  modport master (
    output dwell, enter_req, exit_req,
    input  ready, outer, inner, done, occupancy
  );

  modport slave (
    input  dwell, enter_req, exit_req,
    output ready, outer, inner, done, occupancy
  );
`else
  modport master (
    output dwell, enter_req, exit_req,
    input  ready, outer, inner, done
  );

  modport slave (
    input  dwell, enter_req, exit_req,
    output ready, outer, inner, done
  );
`endif

endinterface

// File: rtl/car_sensor_driver_phase_timer.sv
// Per-phase dwell timer. Loads a value, counts down to zero and holds there.
//   clk_i      : clock
//   rst_ni     : asynchronous active-low reset (count cleared to 0)
//   load_i     : load load_val_i this cycle (wins over counting)
//   load_val_i : value to load (phase length minus one)
//   expired_o  : count has reached zero; the current phase ends this cycle
module car_sensor_driver_phase_timer #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [DWELL_W-1:0] load_val_i,
  output logic               expired_o
);

  logic [DWELL_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - DWELL_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/car_sensor_driver.sv
// Car sensor driver: turns enter/exit requests into the outer/inner beam waveform of a real car.
//   clk     : clock, all state on posedge
//   reset_n : asynchronous active-low reset
//   bus     : car_sensor_driver_if.slave (dwell/enter_req/exit_req in; ready/outer/inner/done out)
// Optional feature macro CAR_OCCUPANCY_EN adds an occupancy counter that gates requests
// (no entering when full, no exiting when empty) and drives bus.occupancy.
module car_sensor_driver
  import car_pkg::*;
#(
  parameter int unsigned DWELL_W  = 8,
  parameter int unsigned MAX_CARS = 16,
  parameter int unsigned OCC_W    = 5
) (
  input logic                 clk,
  input logic                 reset_n,
  car_sensor_driver_if.slave  bus
);

  if (OCC_W < $clog2(MAX_CARS + 1)) begin : g_occ_w_check
    $error("OCC_W cannot hold MAX_CARS");
  end

  car_drv_state_t     state_q, state_d;
  car_dir_t           dir_q, dir_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [1:0]         beams_q, beams_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;

  logic               tmr_load;
  logic [DWELL_W-1:0] tmr_val;
  logic               tmr_expired;

  logic [DWELL_W-1:0] dwell_eff;
  logic               accept_enter;
  logic               accept_exit;

  // A zero dwell would give an empty phase; treat it as one cycle.
  assign dwell_eff = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;

`ifdef CAR_OCCUPANCY_EN
  logic [OCC_W-1:0] occ_q, occ_d;

  // Enter wins a tie, unless the lot is full; then a pending exit is taken instead.
  assign accept_enter = bus.enter_req && (occ_q != OCC_W'(MAX_CARS));
  assign accept_exit  = bus.exit_req && (occ_q != '0) && !accept_enter;

  always_comb begin
    occ_d = occ_q;
    if (done_d) begin
      occ_d = (dir_q == DIR_ENTER) ? occ_q + OCC_W'(1) : occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign bus.occupancy = occ_q;
`else
  assign accept_enter = bus.enter_req;
  assign accept_exit  = bus.exit_req && !bus.enter_req;
`endif

  car_sensor_driver_phase_timer #(
    .DWELL_W (DWELL_W)
  ) u_phase_timer (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_expired)
  );

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    dwell_d  = dwell_q;
    tmr_load = 1'b0;
    tmr_val  = dwell_q - DWELL_W'(1);
    unique case (state_q)
      S_IDLE: begin
        if (accept_enter || accept_exit) begin
          state_d  = S_PH1;
          dir_d    = accept_enter ? DIR_ENTER : DIR_EXIT;
          dwell_d  = dwell_eff;
          tmr_load = 1'b1;
          tmr_val  = dwell_eff - DWELL_W'(1);
        end
      end
      S_PH1: begin
        if (tmr_expired) begin
          state_d  = S_PH2;
          tmr_load = 1'b1;
        end
      end
      S_PH2: begin
        if (tmr_expired) begin
          state_d  = S_PH3;
          tmr_load = 1'b1;
        end
      end
      S_PH3: begin
        if (tmr_expired) begin
          state_d  = S_GAP;
          tmr_load = 1'b1;
        end
      end
      S_GAP: begin
        if (tmr_expired) begin
          state_d  = S_IDLE;
          tmr_load = 1'b1;
          tmr_val  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  assign beams_d = beam_pattern(state_d, dir_d);
  assign ready_d = (state_d == S_IDLE);
  assign done_d  = (state_q == S_PH3) && (state_d == S_GAP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      dir_q   <= DIR_ENTER;
      dwell_q <= '0;
      beams_q <= BEAM_NONE;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      dwell_q <= dwell_d;
      beams_q <= beams_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign bus.outer = beams_q[1];
  assign bus.inner = beams_q[0];
  assign bus.done  = done_q;
  assign bus.ready = ready_q;

endmodule

// File: tb/tb_car_sensor_driver.sv
// Randomised + directed bench for car_sensor_driver against a cycle-list reference model.
module tb_car_sensor_driver;

  localparam int unsigned DW   = 8;
  localparam int unsigned MAXC = 2;
  localparam int unsigned OW   = 5;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

`ifdef CAR_OCCUPANCY_EN
  car_sensor_driver_if #(.DWELL_W(DW), .OCC_W(OW)) bus ();
`else
  car_sensor_driver_if #(.DWELL_W(DW)) bus ();
`endif

  car_sensor_driver #(
    .DWELL_W  (DW),
    .MAX_CARS (MAXC),
    .OCC_W    (OW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: on accept, the whole sequence is expanded into a list of per-cycle
  // expectations {beams, done, ready, occupancy}; the list is consumed one entry per clock.
  typedef struct packed {
    logic [1:0] beams;
    logic       done;
    logic       ready;
    logic [7:0] occ;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   m_occ;
  logic [1:0] enter_tab [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0] exit_tab  [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      m_occ = 0;
      cur = '{beams: 2'b00, done: 1'b0, ready: 1'b1, occ: 8'd0};
    end else begin
      bit can_en, can_ex;
      int d, delta;
`ifdef CAR_OCCUPANCY_EN
      can_en = bus.enter_req && (m_occ < MAXC);
      can_ex = bus.exit_req && (m_occ > 0);
`else
      can_en = bus.enter_req;
      can_ex = bus.exit_req;
`endif
      if (cur.ready && (can_en || can_ex)) begin
        d = (bus.dwell == 0) ? 1 : int'(bus.dwell);
        delta = can_en ? 1 : -1;
        for (int k = 0; k < 4 * d; k++) begin
          exp_t e;
          e.beams = can_en ? enter_tab[k / d] : exit_tab[k / d];
          e.done  = (k == 3 * d);
          e.ready = 1'b0;
          e.occ   = 8'((k >= 3 * d) ? m_occ + delta : m_occ);
          q.push_back(e);
        end
      end
      if (q.size() > 0) cur = q.pop_front();
      else cur = '{beams: 2'b00, done: 1'b0, ready: 1'b1, occ: 8'(m_occ)};
      if (cur.done) m_occ = int'(cur.occ);
    end
  end

  always @(negedge clk) begin
    if (cmp_en && reset_n) begin
`ifdef CAR_OCCUPANCY_EN
      check("cycle", {bus.outer, bus.inner, bus.done, bus.ready, 8'(bus.occupancy)},
            {cur.beams, cur.done, cur.ready, cur.occ});
`else
      check("cycle", {bus.outer, bus.inner, bus.done, bus.ready},
            {cur.beams, cur.done, cur.ready});
`endif
    end
  end

  // One request from idle; measures cycles (1 = first cycle after accept edge) to done and ready.
  task automatic directed(input string name, input logic en, input logic ex, input logic [7:0] dw,
                          input logic [1:0] exp_b1, input logic [1:0] exp_b3,
                          input int exp_done, input int exp_ready);
    int n, done_at, ready_at, dwe;
    logic [1:0] b1, b2, b3;
    dwe = (dw == 0) ? 1 : int'(dw);
    done_at = -1; ready_at = -1; b2 = 2'bxx; b3 = 2'bxx;
    @(negedge clk);
    bus.enter_req = en; bus.exit_req = ex; bus.dwell = dw;
    @(negedge clk);
    bus.enter_req = 1'b0; bus.exit_req = 1'b0;
    n = 1;
    b1 = {bus.outer, bus.inner};
    while (n <= 1200 && ready_at < 0) begin
      if (n == dwe + 1) b2 = {bus.outer, bus.inner};
      if (n == 2 * dwe + 1) b3 = {bus.outer, bus.inner};
      if (bus.done && done_at < 0) done_at = n;
      if (bus.ready) ready_at = n;
      if (ready_at < 0) begin
        @(negedge clk);
        n++;
      end
    end
    check({name, " ph1 beams"}, 32'(b1), 32'(exp_b1));
    check({name, " ph2 beams"}, 32'(b2), 32'(2'b11));
    check({name, " ph3 beams"}, 32'(b3), 32'(exp_b3));
    check({name, " done cycle"}, done_at, exp_done);
    check({name, " ready cycle"}, ready_at, exp_ready);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!bus.ready && n < 1200) begin
      @(negedge clk);
      n++;
    end
    check({name, " ready seen"}, 32'(bus.ready), 32'd1);
  endtask

`ifdef CAR_OCCUPANCY_EN
  task automatic req_and_wait(input logic en, input logic ex, input logic [7:0] dw);
    @(negedge clk);
    bus.enter_req = en; bus.exit_req = ex; bus.dwell = dw;
    @(negedge clk);
    bus.enter_req = 1'b0; bus.exit_req = 1'b0;
    wait_ready("occ seq");
  endtask

  task automatic refused(input string name, input logic en, input logic ex, input int occ_exp);
    @(negedge clk);
    bus.enter_req = en; bus.exit_req = ex; bus.dwell = 8'd1;
    repeat (3) begin
      @(negedge clk);
      check({name, " ready held"}, 32'(bus.ready), 32'd1);
      check({name, " beams idle"}, 32'({bus.outer, bus.inner}), 32'd0);
    end
    bus.enter_req = 1'b0; bus.exit_req = 1'b0;
    check({name, " occupancy"}, 32'(bus.occupancy), occ_exp);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    bus.enter_req = 1'b0;
    bus.exit_req  = 1'b0;
    bus.dwell     = '0;

    // Power-on reset.
    #1 reset_n = 1'b0;
    #1;
    check("reset beams", 32'({bus.outer, bus.inner}), 32'd0);
    check("reset ready", 32'(bus.ready), 32'd1);
    check("reset done", 32'(bus.done), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cmp_en  = 1'b1;

    // Reset mid-sequence drops the beams at once and abandons the car.
    @(negedge clk);
    bus.enter_req = 1'b1; bus.dwell = 8'd3;
    @(negedge clk);
    bus.enter_req = 1'b0;
    repeat (4) @(negedge clk);
    check("mid-seq beams before reset", 32'({bus.outer, bus.inner}), 32'(2'b11));
    #2 reset_n = 1'b0;
    #1;
    check("async reset beams", 32'({bus.outer, bus.inner}), 32'd0);
    check("async reset ready", 32'(bus.ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post-reset ready", 32'(bus.ready), 32'd1);
    check("post-reset done", 32'(bus.done), 32'd0);
`ifdef CAR_OCCUPANCY_EN
    check("post-reset occupancy", 32'(bus.occupancy), 32'd0);
`endif

    directed("enter d3", 1'b1, 1'b0, 8'd3, 2'b10, 2'b01, 10, 13);
    directed("exit d0", 1'b0, 1'b1, 8'd0, 2'b01, 2'b10, 4, 5);
    directed("both d2", 1'b1, 1'b1, 8'd2, 2'b10, 2'b01, 7, 9);
    repeat (5) @(negedge clk);
    check("no replay of exit", 32'({bus.outer, bus.inner, bus.ready}), 32'(3'b001));

    // Exit pulsed during PH2 must be ignored.
    @(negedge clk);
    bus.enter_req = 1'b1; bus.dwell = 8'd2;
    @(negedge clk);
    bus.enter_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("busy in ph2", 32'({bus.outer, bus.inner, bus.ready}), 32'(3'b110));
    bus.exit_req = 1'b1;
    @(negedge clk);
    bus.exit_req = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) dones++;
      @(negedge clk);
    end
    check("single done after busy exit", dones, 1);
    check("idle after busy exit", 32'({bus.outer, bus.inner, bus.ready}), 32'(3'b001));

    // Maximum dwell (exit so the lot does not fill in occupancy builds).
    directed("exit d255", 1'b0, 1'b1, 8'd255, 2'b01, 2'b10, 766, 1021);

    // Random requests; model tracks acceptance.
    for (int i = 0; i < 1500; i++) begin
      int r;
      @(negedge clk);
      r = $urandom_range(0, 9);
      bus.enter_req = (r < 2) || (r == 4);
      bus.exit_req  = (r == 2) || (r == 3) || (r == 4);
      bus.dwell     = ($urandom_range(0, 29) == 0) ? 8'($urandom_range(5, 40))
                                                   : 8'($urandom_range(0, 4));
    end
    @(negedge clk);
    bus.enter_req = 1'b0; bus.exit_req = 1'b0;
    wait_ready("after random");

`ifdef CAR_OCCUPANCY_EN
    #2 reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_and_wait(1'b1, 1'b0, 8'd1);
      check("occ after enter", 32'(bus.occupancy), i + 1);
    end
    refused("enter when full", 1'b1, 1'b0, 2);
    // Full lot with both requests: exit is taken.
    @(negedge clk);
    bus.enter_req = 1'b1; bus.exit_req = 1'b1; bus.dwell = 8'd1;
    @(negedge clk);
    bus.enter_req = 1'b0; bus.exit_req = 1'b0;
    check("full tie takes exit", 32'({bus.outer, bus.inner}), 32'(2'b01));
    wait_ready("full tie");
    check("occ after tie exit", 32'(bus.occupancy), 32'd1);
    req_and_wait(1'b0, 1'b1, 8'd1);
    check("occ after exit", 32'(bus.occupancy), 32'd0);
    refused("exit when empty", 1'b0, 1'b1, 0);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
